// File: rtl/mult_share_pkg.sv
// Shared types and widths for the multiplier-sharing block.
package mult_share_pkg;

  localparam int MULT_W   = 8;
  localparam int PROD_W   = 16;
  // Widest requester index carried in the stage records (NUM_REQ tops out at 16).
  localparam int MAX_ID_W = 4;

  // Operand record held in the first pipeline stage.
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [MULT_W-1:0]   a;
    logic [MULT_W-1:0]   b;
  } mult_op_t;

  // Product record held in the output stage.
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [PROD_W-1:0]   product;
  } mult_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker. The search starts just after
// i_last and wraps; the first asserted request wins. Kept generic so other
// shared-resource blocks can reuse it.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  input  logic             i_en,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_req_hi;
  logic [N-1:0] w_pick_src;
  logic [N-1:0] w_onehot;

  // Positions strictly above the last winner get first look.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign w_mask[gi] = (IDX_W'(gi) > i_last);
    end
  endgenerate

  // If nothing is requesting above the pointer, wrap to the full vector.
  assign w_req_hi   = i_req & w_mask;
  assign w_pick_src = (|w_req_hi) ? w_req_hi : i_req;
  // Isolate the lowest set bit of the chosen vector.
  assign w_onehot   = w_pick_src & (~w_pick_src + N'(1));

  assign o_grant = i_en ? w_onehot : '0;
  assign o_any   = i_en & (|i_req);

  // Encode the one-hot winner into an index.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_onehot[i]) begin
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wallace_tree_multiplier_8x8.sv
// wallace_tree_multiplier_8x8: unsigned 8x8 -> 16 combinational multiplier.
// Eight partial-product rows are reduced by layers of 3:2 carry-save adders
// down to two rows, which a single carry-propagate adder then sums.
module wallace_tree_multiplier_8x8 (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P
);

  logic [15:0] w_pp [8];

  // Partial product row gi is A gated by B[gi], shifted into place.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pp
      assign w_pp[gi] = {8'h00, A & {8{B[gi]}}} << gi;
    end
  endgenerate

  function automatic logic [15:0] csa_sum(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csa_carry(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  // Layer 1: 8 rows -> 6
  logic [15:0] w_s_a, w_c_a, w_s_b, w_c_b;
  assign w_s_a = csa_sum  (w_pp[0], w_pp[1], w_pp[2]);
  assign w_c_a = csa_carry(w_pp[0], w_pp[1], w_pp[2]);
  assign w_s_b = csa_sum  (w_pp[3], w_pp[4], w_pp[5]);
  assign w_c_b = csa_carry(w_pp[3], w_pp[4], w_pp[5]);

  // Layer 2: 6 rows -> 4
  logic [15:0] w_s_c, w_c_c, w_s_d, w_c_d;
  assign w_s_c = csa_sum  (w_s_a, w_c_a, w_s_b);
  assign w_c_c = csa_carry(w_s_a, w_c_a, w_s_b);
  assign w_s_d = csa_sum  (w_c_b, w_pp[6], w_pp[7]);
  assign w_c_d = csa_carry(w_c_b, w_pp[6], w_pp[7]);

  // Layer 3: 4 rows -> 3
  logic [15:0] w_s_e, w_c_e;
  assign w_s_e = csa_sum  (w_s_c, w_c_c, w_s_d);
  assign w_c_e = csa_carry(w_s_c, w_c_c, w_s_d);

  // Layer 4: 3 rows -> 2
  logic [15:0] w_s_f, w_c_f;
  assign w_s_f = csa_sum  (w_s_e, w_c_e, w_c_d);
  assign w_c_f = csa_carry(w_s_e, w_c_e, w_c_d);

  // The true product always fits in 16 bits, so the modulo-2^16 sum is exact.
  assign P = w_s_f + w_c_f;

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one combinational 8x8 multiplier among NUM_REQ
// requesters. Round-robin arbitration feeds an operand register; the tree sits
// between that register and the product register that drives the response.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [MULT_W*NUM_REQ-1:0]   req_a,
  input  logic [MULT_W*NUM_REQ-1:0]   req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [PROD_W-1:0]           rsp_product,
  output logic                        busy
);

  logic              r_s1_valid;
  mult_op_t          r_s1_op;
  logic              r_s2_valid;
  mult_rsp_t         r_s2_rsp;
  logic [ID_W-1:0]   r_last;

  logic              w_adv1;
  logic              w_adv2;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]   w_grant_idx;
  logic              w_any_grant;
  logic [MULT_W-1:0] w_sel_a;
  logic [MULT_W-1:0] w_sel_b;
  logic [PROD_W-1:0] w_product;
  logic [MULT_W-1:0] w_lane_a [NUM_REQ];
  logic [MULT_W-1:0] w_lane_b [NUM_REQ];

  // The output slot frees up when empty or when the consumer takes it; the
  // operand slot frees up when empty or when it can push into the output slot.
  assign w_adv2 = !r_s2_valid | rsp_ready;
  assign w_adv1 = !r_s1_valid | w_adv2;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_last  (r_last),
    .i_en    (w_adv1),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_any_grant)
  );

  // Grant is already gated by w_adv1, so it is exactly the ready vector.
  assign req_ready = w_grant;

  // Split the packed operand buses into per-requester lanes.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign w_lane_a[gi] = req_a[MULT_W*gi +: MULT_W];
      assign w_lane_b[gi] = req_b[MULT_W*gi +: MULT_W];
    end
  endgenerate

  // AND-OR select of the granted requester's operands.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = w_sel_a | w_lane_a[i];
        w_sel_b = w_sel_b | w_lane_b[i];
      end
    end
  end

  wallace_tree_multiplier_8x8 u_mult (
    .A (r_s1_op.a),
    .B (r_s1_op.b),
    .P (w_product)
  );

  // Operand stage: load the winner whenever the slot can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= w_any_grant;
      r_s1_op.id <= MAX_ID_W'(w_grant_idx);
      r_s1_op.a  <= w_sel_a;
      r_s1_op.b  <= w_sel_b;
    end
  end

  // Product stage: capture the tree output; holds steady under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid       <= 1'b0;
      r_s2_rsp         <= '0;
    end else if (w_adv2) begin
      r_s2_valid       <= r_s1_valid;
      r_s2_rsp.id      <= r_s1_op.id;
      r_s2_rsp.product <= w_product;
    end
  end

  // Round-robin pointer moves only on a completed request handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= ID_W'(NUM_REQ - 1);
    end else if (w_any_grant) begin
      r_last <= w_grant_idx;
    end
  end

  assign rsp_valid   = r_s2_valid;
  assign rsp_id      = r_s2_rsp.id[ID_W-1:0];
  assign rsp_product = r_s2_rsp.product;
  assign busy        = r_s1_valid | r_s2_valid;

  // Index bits above ID_W are always zero for narrower configurations.
  generate
    if (ID_W < MAX_ID_W) begin : g_id_pad
      logic w_unused_id_hi;
      assign w_unused_id_hi = |r_s2_rsp.id[MAX_ID_W-1:ID_W];
    end
  endgenerate

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) && $stable(rsp_product)));

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

  localparam int N   = 4;
  localparam int IDW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [8*N-1:0]  req_a;
  logic [8*N-1:0]  req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [15:0]     rsp_product;
  logic            busy;

  logic [7:0] op_a [N];
  logic [7:0] op_b [N];

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[8*i +: 8] = op_a[i];
      req_b[8*i +: 8] = op_b[i];
    end
  end

  mult_share_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Two slots: "mid" (accepted, not yet visible) and "out" (visible response).
  int           m_last   = N - 1;
  bit           m_mid_v  = 1'b0;
  int           m_mid_id = 0;
  int           m_mid_p  = 0;
  bit           m_out_v  = 1'b0;
  int           m_out_id = 0;
  int           m_out_p  = 0;
  bit [N-1:0]   m_acc    = '0;
  int           m_accepts = 0;
  int           dut_rsps  = 0;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = rr_pick(req_valid, m_last);
    if ((!m_mid_v || !m_out_v || rsp_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    bit out_moves;
    int g;
    m_acc = '0;
    if (rst) begin
      m_last  = N - 1;
      m_mid_v = 1'b0;
      m_out_v = 1'b0;
    end else begin
      out_moves = !m_out_v || rsp_ready;
      g = rr_pick(req_valid, m_last);
      if (out_moves) begin
        m_out_v  = m_mid_v;
        m_out_id = m_mid_id;
        m_out_p  = m_mid_p;
        m_mid_v  = 1'b0;
      end
      if (!m_mid_v && g >= 0) begin
        m_mid_v  = 1'b1;
        m_mid_id = g;
        m_mid_p  = int'(op_a[g]) * int'(op_b[g]);
        m_acc[g] = 1'b1;
        m_last   = g;
        m_accepts++;
      end
    end
  end

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rsp_valid", rsp_valid, m_out_v);
      chk("busy", busy, m_mid_v || m_out_v);
      chk("req_ready", req_ready, exp_ready());
      if (m_out_v) begin
        chk("rsp_id", rsp_id, m_out_id);
        chk("rsp_product", rsp_product, m_out_p);
      end
      if (rsp_valid && rsp_ready) begin
        dut_rsps++;
        $display("rsp id=%0d product=%0d t=%0t", rsp_id, rsp_product, $time);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] edge_vals [4];
    edge_vals[0] = 8'd0;
    edge_vals[1] = 8'd1;
    edge_vals[2] = 8'd128;
    edge_vals[3] = 8'd255;
    if ($urandom_range(0, 4) == 0) return edge_vals[$urandom_range(0, 3)];
    return 8'($urandom_range(0, 255));
  endfunction

  int got_id [$];
  int got_p  [$];
  int exp_c_id [6] = '{0, 1, 2, 3, 0, 1};
  int exp_c_p  [6] = '{10, 20, 30, 40, 10, 20};
  int exp_e_p  [4] = '{0, 255, 256, 0};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int base_acc;
    int base_rsp;
    int cyc;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_product", rsp_product, 0);
    chk("reset_req_ready", req_ready, 0);

    // Single requester, largest operands
    step();
    op_a[2] = 8'd255; op_b[2] = 8'd255;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 2);
    chk("single_rsp_product", rsp_product, 65025);
    step();
    @(negedge clk);
    chk("single_idle_busy", busy, 0);

    // Full contention from reset
    do_reset();
    for (int i = 0; i < N; i++) begin
      op_a[i] = 8'(i + 1);
      op_b[i] = 8'd10;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    got_id.delete();
    got_p.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got_id.push_back(int'(rsp_id));
        got_p.push_back(int'(rsp_product));
      end
      step();
    end
    req_valid = '0;
    chk("contention_count", got_id.size(), 6);
    for (int k = 0; k < 6 && k < got_id.size(); k++) begin
      chk("contention_id", got_id[k], exp_c_id[k]);
      chk("contention_product", got_p[k], exp_c_p[k]);
    end

    // Backpressure
    do_reset();
    op_a[1] = 8'd5; op_b[1] = 8'd7;
    op_a[3] = 8'd9; op_b[3] = 8'd11;
    req_valid = 4'b1010;
    rsp_ready = 1'b0;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_id", rsp_id, 1);
      chk("bp_rsp_product", rsp_product, 35);
      chk("bp_req_ready", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    got_id.delete();
    got_p.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        got_id.push_back(int'(rsp_id));
        got_p.push_back(int'(rsp_product));
      end
      step();
    end
    chk("bp_drain_count", got_id.size(), 2);
    if (got_id.size() == 2) begin
      chk("bp_first_id", got_id[0], 1);
      chk("bp_first_product", got_p[0], 35);
      chk("bp_second_id", got_id[1], 3);
      chk("bp_second_product", got_p[1], 99);
    end

    // Edge operands on requester 0
    do_reset();
    rsp_ready = 1'b1;
    got_p.delete();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin op_a[0] = 8'd0;   op_b[0] = 8'd200; req_valid = 4'b0001; end
        1: begin op_a[0] = 8'd1;   op_b[0] = 8'd255; end
        2: begin op_a[0] = 8'd128; op_b[0] = 8'd2;   end
        3: begin op_a[0] = 8'd255; op_b[0] = 8'd0;   end
        default: req_valid = '0;
      endcase
      @(negedge clk);
      if (rsp_valid) got_p.push_back(int'(rsp_product));
      step();
    end
    chk("edge_count", got_p.size(), 4);
    for (int k = 0; k < 4 && k < got_p.size(); k++) begin
      chk("edge_product", got_p[k], exp_e_p[k]);
    end

    // Pointer hold across a stall
    do_reset();
    rsp_ready = 1'b0;
    op_a[3] = 8'd3; op_b[3] = 8'd4;
    req_valid = 4'b1000;
    step();
    op_a[0] = 8'd6; op_b[0] = 8'd7;
    op_a[1] = 8'd8; op_b[1] = 8'd9;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_stalled_ready", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_grant_after_stall", req_ready, 4'b0010);
    step();
    req_valid = '0;
    for (int c = 0; c < 4; c++) step();

    // Randomized traffic
    do_reset();
    base_acc = m_accepts;
    base_rsp = dut_rsps;
    cyc = 0;
    while (cyc < 6000 && (m_accepts - base_acc) < 1000) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !m_acc[i]) begin
          if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          op_a[i] = pick_operand();
          op_b[i] = pick_operand();
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
      cyc++;
    end
    chk("random_accept_budget", ((m_accepts - base_acc) >= 1000) ? 1 : 0, 1);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    chk("random_no_loss", dut_rsps - base_rsp, m_accepts - base_acc);

    // Reset with both stages full
    rsp_ready = 1'b0;
    op_a[2] = 8'd12; op_b[2] = 8'd13;
    op_a[3] = 8'd14; op_b[3] = 8'd15;
    req_valid = 4'b1100;
    step();
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = '1;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_first_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Shares one combinational wallace_tree_multiplier_8x8 (ports A, B, P) among NUM_REQ independent requesters in the accelerator's MAC array.
- Round-robin arbitration, valid/ready handshake on each requester and on the single response channel.
- Two-stage pipeline (operand register -> multiplier -> product register) so the combinational tree sits between flops.
- Sustains one product per cycle when unstalled.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, $clog2(NUM_REQ), width of requester index

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept; at most one bit set
req_a  input  8*NUM_REQ  operand A, requester i at bits [8i+7:8i]
req_b  input  8*NUM_REQ  operand B, same packing
rsp_valid  output  1  product valid
rsp_ready  input  1  consumer accepts product
rsp_id  output  ID_W  index of requester owning rsp_product
rsp_product  output  16  unsigned A*B
busy  output  1  s1_valid | s2_valid

Behaviour:
- Reset (synchronous, active-high):
  - s1_valid=0, s2_valid=0, rsp_valid=0, rsp_product=0, rsp_id=0.
  - RR pointer last=NUM_REQ-1, so requester 0 has top priority after reset.
  - Reset mid-operation discards in-flight operands and products with no response.
- Stage 2 (output register): adv2 = !s2_valid | rsp_ready. On adv2, s2 takes s1 contents and product P; s2_valid <= s1_valid.
- Stage 1 (operand register): adv1 = !s1_valid | adv2. On adv1, s1 loads the granted requester's a, b and id; s1_valid <= any_grant.
- Arbitration (combinational):
  - Scan req_valid starting at index last+1, wrapping modulo NUM_REQ; first set bit is the grant.
  - req_ready[g] = adv1 & req_valid[g]; all other bits 0.
  - Handshake on requester g completes when req_valid[g] & req_ready[g].
  - last <= g only on a completed handshake; unchanged otherwise, including under stall.
- Latency: accept in cycle N -> rsp_valid=1 in cycle N+2 (no stall).
- Throughput: 1 accept per cycle while rsp_ready=1.
- Backpressure:
  - rsp_valid=1 & rsp_ready=0 holds rsp_product and rsp_id stable.
  - s1 holds if also full; req_ready goes all-0 when both stages are full.
- Simultaneous rsp handshake and s1 advance in the same cycle is legal, giving a full-rate bubble-free stream.
- Requester rules:
  - req_valid must not depend on req_ready.
  - Operands must stay stable while valid is high and not accepted.
  - A requester may drop valid without penalty.
- Arithmetic: unsigned 8x8 -> 16 bit, no truncation; 255*255=65025.
- Fairness: with all requesters continuously valid, grants follow 0,1,...,NUM_REQ-1,0...
- Ordering: responses return in acceptance order; rsp_id tags each response.

Decomposition:
- Package mult_share_pkg:
  - MULT_W=8, PROD_W=16.
  - typedef mult_op_t {id, a, b}.
  - typedef mult_rsp_t {id, product}.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, last pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Reusable by later shared-resource blocks.
- Multiplier instantiated unchanged as wallace_tree_multiplier_8x8.

Test Plan:
- Single requester: req 2 only, a=255 b=255, rsp_ready=1 -> req_ready[2]=1 same cycle; two cycles later rsp_valid=1, rsp_id=2, rsp_product=65025; then idle, busy=0.
- Full contention: all 4 valid continuously, a=i+1 b=10 for requester i -> rsp_id sequence 0,1,2,3,0,1; products 10,20,30,40; one response per cycle.
- Backpressure: stream from req 1 and 3, rsp_ready=0 for 5 cycles -> rsp_valid/rsp_id/rsp_product stable; req_ready all-0 after 2 accepts; releasing rsp_ready delivers in order with no loss or duplication.
- Edge operands: (0,200)->0, (1,255)->255, (128,2)->256, (255,0)->0; spot-check against a*b, plus 1000 random pairs over random requesters.
- Pointer hold: req 0 granted, then req 0 and 1 valid while stalled -> req 1 granted first after the stall clears (last=0 preserved).
- Reset mid-operation: assert rst with both stages full -> next cycle rsp_valid=0, busy=0, no stale response; first grant afterwards goes to requester 0.
